des_round_engine: RTL and testbench
===================================

# des_round_engine

Iterative DES/DES-decrypt engine that feeds the `s_box` stage and consumes its 32-bit output. It accepts a 64-bit block and 64-bit key, then runs 16 Feistel rounds, one per clock. Each round forms E(R) XOR K for `s_box` and applies the P permutation and the L/R swap to its result. Key schedule (PC-1, rotations, PC-2), IP and FP are internal. The block sits between the cipher's input stream and output stream.

## Interface
- (no parameters)

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  a block/key/mode is offered.
- `in_ready`  out  1  the engine can accept; high only in IDLE.
- `in_data`  in  64  plaintext (encrypt) or ciphertext (decrypt); DES bit 1 = bit 63.
- `in_key`  in  64  DES key; bits 56,48,…,0 are parity and ignored.
- `in_decrypt`  in  1  1 = decrypt (subkeys K16..K1), 0 = encrypt.
- `out_valid`  out  1  result held on `out_data`.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  64  result block.
- `busy`  out  1  high in ROUND or DONE.

## Operation
- States: IDLE, ROUND, DONE.
- IDLE: `in_ready`=1. On `in_valid & in_ready`:
  - capture `in_data`, `in_key`, `in_decrypt`;
  - {L,R} <= IP(in_data);
  - {C,D} <= PC-1(in_key) as two 28-bit halves;
  - round counter r <= 0;
  - go to ROUND.
- ROUND, every cycle:
  - Shift table, rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Encrypt: C',D' = C,D rotated left by shift[r+1]. K = PC-2(C',D'). C,D <= C',D'.
  - Decrypt: K = PC-2(C,D), using the unrotated halves. Then C,D <= C,D rotated right by shift[16-r]. The r=0 key therefore equals K16.
  - `s_box` input (48 bits, bit 47 = DES bit 1) = E(R) XOR K.
  - f = P(`s_box` output).
  - L <= R; R <= L XOR f; r <= r+1.
  - When r=15, the round completes, `out_data` <= FP({R16,L16}) (the final swap is undone), and the state goes to DONE.
- DONE: `out_valid`=1. `out_data` is stable until `out_valid & out_ready`, then the state goes to IDLE.
- Input handshake:
  - `in_valid` is ignored outside IDLE.
  - `in_data`/`in_key`/`in_decrypt` changes after acceptance have no effect.
- Parity bits never influence the result.
- Counter r is 4 bits. It never wraps inside a block and is reloaded to 0 at each accept.
- Reset, including mid-operation:
  - state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, `out_data`=0;
  - L, R, C, D, r = 0;
  - an in-flight block is discarded and no output is produced for it.

## Timing
- Accept at edge T. Rounds 1..16 complete at edges T+1..T+16. `out_valid` is high from just after T+16.
- Latency: 16 cycles from the accept edge to `out_valid`.
- With `out_ready`=1 held:
  - the result handshakes at edge T+17 and the state returns to IDLE;
  - the next accept is at T+18, giving one block per 18 cycles.
- `out_ready` low stalls in DONE indefinitely. `in_ready` stays 0 during the stall.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- Critical path: E → XOR → `s_box` → P → XOR, in one cycle.

## Test plan
- Encrypt: key 133457799BBCDFF1, data 0123456789ABCDEF → `out_data`=85E813540F0AB405. `out_valid` rises exactly 16 cycles after the accept edge.
- Decrypt: same key, data 85E813540F0AB405 → 0123456789ABCDEF. Also key 0E329232EA6D0D73, data 0000000000000000 → 8787878787878787.
- Parity: encrypt 0123456789ABCDEF with key 123556789ABDDEF0 (all parity bits flipped) → 85E813540F0AB405.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE, with `in_valid`=1 and new data applied meanwhile →
  - `out_valid` stays 1 and `out_data` stays 85E813540F0AB405;
  - `in_ready` stays 0;
  - after release, the next accept occurs one cycle after the handshake.
- Back-to-back: 4 blocks with `out_ready`=1 → accepts are spaced 18 cycles apart, all results are correct, and there are no dropped or duplicated `out_valid` pulses.
- Reset mid-operation: assert `rst_n`=0 during round 8 →
  - `out_valid`=0, `out_data`=0, `in_ready`=1 immediately (asynchronous);
  - after release, the encrypt vector above still yields 85E813540F0AB405.

Source files
------------

// File: rtl/des_round_engine_if.sv
// Block/key/mode input channel and result output channel of the DES round engine.
interface des_round_engine_if;
   localparam int unsigned BLK_W = 64;

   logic             in_valid;
   logic             in_ready;
   logic [BLK_W-1:0] in_data;
   logic [BLK_W-1:0] in_key;
   logic             in_decrypt;
   logic             out_valid;
   logic             out_ready;
   logic [BLK_W-1:0] out_data;

   modport master (
      output in_valid, in_data, in_key, in_decrypt, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_key, in_decrypt, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/des_round_engine.sv
// Iterative DES encrypt/decrypt engine: one Feistel round per clock, 16 rounds per block.
// Key schedule, IP/FP, E, S-boxes and P are all computed internally.
module des_round_engine (
   input  logic              clk,
   input  logic              rst_n,
   des_round_engine_if.slave bus,
   output logic              busy
);
   localparam int unsigned BLK_W  = 64;
   localparam int unsigned HALF_W = 32;
   localparam int unsigned KEY_W  = 56;
   localparam int unsigned CD_W   = 28;
   localparam int unsigned SUB_W  = 48;
   localparam int unsigned RND_W  = 4;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   // Permutation tables in DES numbering (bit 1 = MSB)
   localparam int unsigned IP_T [64] = '{
      58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
      57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
   localparam int unsigned FP_T [64] = '{
      40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
      36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
   localparam int unsigned E_T [48] = '{
      32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
      16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
   localparam int unsigned P_T [32] = '{
      16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
   localparam int unsigned PC1_T [56] = '{
      57,49,41,33,25,17,9,1, 58,50,42,34,26,18,10,2, 59,51,43,35,27,19,11,3, 60,52,44,36,
      63,55,47,39,31,23,15,7, 62,54,46,38,30,22,14,6, 61,53,45,37,29,21,13,5, 28,20,12,4};
   localparam int unsigned PC2_T [48] = '{
      14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
      41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

   // S1..S8, each 4 rows x 16 columns
   localparam int unsigned SBOX_T [512] = '{
      14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
      15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
      10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
      7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
      2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
      12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
      4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
      13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

   function automatic logic [BLK_W-1:0] ip_perm(input logic [BLK_W-1:0] x);
      ip_perm = '0;
      for (int i = 0; i < 64; i++) ip_perm[6'(63 - i)] = x[6'(64 - IP_T[i])];
   endfunction

   function automatic logic [BLK_W-1:0] fp_perm(input logic [BLK_W-1:0] x);
      fp_perm = '0;
      for (int i = 0; i < 64; i++) fp_perm[6'(63 - i)] = x[6'(64 - FP_T[i])];
   endfunction

   function automatic logic [SUB_W-1:0] e_expand(input logic [HALF_W-1:0] x);
      e_expand = '0;
      for (int i = 0; i < 48; i++) e_expand[6'(47 - i)] = x[5'(32 - E_T[i])];
   endfunction

   function automatic logic [HALF_W-1:0] p_perm(input logic [HALF_W-1:0] x);
      p_perm = '0;
      for (int i = 0; i < 32; i++) p_perm[5'(31 - i)] = x[5'(32 - P_T[i])];
   endfunction

   function automatic logic [KEY_W-1:0] pc1(input logic [BLK_W-1:0] x);
      pc1 = '0;
      for (int i = 0; i < 56; i++) pc1[6'(55 - i)] = x[6'(64 - PC1_T[i])];
   endfunction

   function automatic logic [SUB_W-1:0] pc2(input logic [KEY_W-1:0] x);
      pc2 = '0;
      for (int i = 0; i < 48; i++) pc2[6'(47 - i)] = x[6'(56 - PC2_T[i])];
   endfunction

   // Row = outer bits of each 6-bit group, column = inner four bits
   function automatic logic [HALF_W-1:0] s_box(input logic [SUB_W-1:0] x);
      logic [5:0] b;
      logic [8:0] idx;
      s_box = '0;
      for (int j = 0; j < 8; j++) begin
         b   = x[6'(47 - 6 * j) -: 6];
         idx = {3'(j), b[5], b[0], b[4:1]};
         s_box[5'(31 - 4 * j) -: 4] = 4'(SBOX_T[idx]);
      end
   endfunction

   // Rounds 1, 2, 9 and 16 shift by one, all others by two
   function automatic logic [1:0] shift_amt(input logic [4:0] n);
      shift_amt = (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16) ? 2'd1 : 2'd2;
   endfunction

   function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x, input logic [1:0] amt);
      rotl28 = (amt == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
   endfunction

   function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x, input logic [1:0] amt);
      rotr28 = (amt == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

   logic [1:0]        state_q, state_d;
   logic [HALF_W-1:0] l_q, l_d, r_q, r_d;
   logic [CD_W-1:0]   c_q, c_d, d_q, d_d;
   logic [RND_W-1:0]  rnd_q, rnd_d;
   logic              dec_q, dec_d;
   logic [BLK_W-1:0]  out_data_q, out_data_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;

   logic [1:0]        amt_enc, amt_dec;
   logic [CD_W-1:0]   c_rot, d_rot;
   logic [SUB_W-1:0]  sub_key, sbox_in;
   logic [HALF_W-1:0] f_out, r_new;
   logic [BLK_W-1:0]  ip_blk;
   logic [KEY_W-1:0]  pc1_key;

   // Round datapath: E -> XOR K -> S-boxes -> P -> XOR L
   always_comb begin
      amt_enc = shift_amt(5'(rnd_q) + 5'd1);
      amt_dec = shift_amt(5'd16 - 5'(rnd_q));
      c_rot   = rotl28(c_q, amt_enc);
      d_rot   = rotl28(d_q, amt_enc);
      sub_key = dec_q ? pc2({c_q, d_q}) : pc2({c_rot, d_rot});
      sbox_in = e_expand(r_q) ^ sub_key;
      f_out   = p_perm(s_box(sbox_in));
      r_new   = l_q ^ f_out;
      ip_blk  = ip_perm(bus.in_data);
      pc1_key = pc1(bus.in_key);
   end

   always_comb begin
      state_d    = state_q;
      l_d        = l_q;
      r_d        = r_q;
      c_d        = c_q;
      d_d        = d_q;
      rnd_d      = rnd_q;
      dec_d      = dec_q;
      out_data_d = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               {l_d, r_d} = ip_blk;
               {c_d, d_d} = pc1_key;
               rnd_d      = '0;
               dec_d      = bus.in_decrypt;
               state_d    = S_ROUND;
            end
         end
         S_ROUND: begin
            l_d = r_q;
            r_d = r_new;
            c_d = dec_q ? rotr28(c_q, amt_dec) : c_rot;
            d_d = dec_q ? rotr28(d_q, amt_dec) : d_rot;
            if (rnd_q == 4'd15) begin
               // Undo the last swap before FP; counter holds rather than wrap
               out_data_d = fp_perm({r_new, r_q});
               state_d    = S_DONE;
            end else begin
               rnd_d = rnd_q + 4'd1;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      in_ready_d  = (state_d == S_IDLE);
      out_valid_d = (state_d == S_DONE);
      busy_d      = (state_d == S_ROUND) || (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         l_q         <= '0;
         r_q         <= '0;
         c_q         <= '0;
         d_q         <= '0;
         rnd_q       <= '0;
         dec_q       <= 1'b0;
         out_data_q  <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         l_q         <= l_d;
         r_q         <= r_d;
         c_q         <= c_d;
         d_q         <= d_d;
         rnd_q       <= rnd_d;
         dec_q       <= dec_d;
         out_data_q  <= out_data_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_des_round_engine.sv
// Scoreboard bench for des_round_engine using published DES vectors.
module tb_des_round_engine;
   logic clk = 1'b0;
   logic rst_n;
   logic busy;

   des_round_engine_if bus();

   des_round_engine dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_AP = 64'h123556789ABDDEF0;
   localparam logic [63:0] KEY_B  = 64'h0E329232EA6D0D73;
   localparam logic [63:0] PT_A   = 64'h0123456789ABCDEF;
   localparam logic [63:0] CT_A   = 64'h85E813540F0AB405;
   localparam logic [63:0] PT_B   = 64'h8787878787878787;
   localparam logic [63:0] CT_B   = 64'h0000000000000000;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int push_cnt = 0;
   int hs_cnt = 0;
   int last_acc = -100;
   int last_hs = -100;
   logic prev_ov = 1'b0;
   logic [63:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Output monitor: compares every handshaked result and checks accept-to-valid latency
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.in_valid && bus.in_ready) last_acc = cyc + 1;
            if (bus.out_valid && !prev_ov) check("latency", 64'(cyc - last_acc), 64'd16);
            if (bus.out_valid && bus.out_ready) begin
               hs_cnt++;
               last_hs = cyc + 1;
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'bx;
               check("result", bus.out_data, e);
            end
         end
         prev_ov = bus.out_valid;
      end
   end

   task automatic send(input logic [63:0] d, input logic [63:0] k, input logic dec,
                       input logic [63:0] e, output int acc_edge);
      int n;
      n = 0;
      bus.in_valid   = 1'b1;
      bus.in_data    = d;
      bus.in_key     = k;
      bus.in_decrypt = dec;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.in_ready && n < 100);
      check("accept_wait", 64'(bus.in_ready), 64'd1);
      exp_q.push_back(e);
      push_cnt++;
      acc_edge = cyc + 1;
      @(posedge clk);
      #1;
      bus.in_valid   = 1'b0;
      bus.in_data    = ~d;
      bus.in_key     = ~k;
      bus.in_decrypt = ~dec;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int acc[4];
      int n;
      rst_n          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.in_key     = '0;
      bus.in_decrypt = 1'b0;
      bus.out_ready  = 1'b1;
      #12;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out_data", bus.out_data, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single blocks: encrypt, decrypt, second key, parity-flipped key
      send(PT_A, KEY_A, 1'b0, CT_A, a);
      repeat (3) @(negedge clk);
      check("busy_round", 64'(busy), 64'd1);
      check("in_ready_round", 64'(bus.in_ready), 64'd0);
      wait_drain();
      send(CT_A, KEY_A, 1'b1, PT_A, a);
      wait_drain();
      send(CT_B, KEY_B, 1'b1, PT_B, a);
      wait_drain();
      send(PT_A, KEY_AP, 1'b0, CT_A, a);
      wait_drain();

      // Backpressure: hold result for 5 cycles while a new block is offered
      bus.out_ready = 1'b0;
      send(PT_A, KEY_A, 1'b0, CT_A, a);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      bus.in_valid   = 1'b1;
      bus.in_data    = CT_A;
      bus.in_key     = KEY_A;
      bus.in_decrypt = 1'b1;
      repeat (5) begin
         @(negedge clk);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_out_data", bus.out_data, CT_A);
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      exp_q.push_back(PT_A);
      push_cnt++;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp_next_accept", 64'(last_acc - last_hs), 64'd1);
      wait_drain();

      // Back-to-back blocks with out_ready held high
      send(PT_B, KEY_B, 1'b0, CT_B, acc[0]);
      send(PT_A, KEY_A, 1'b0, CT_A, acc[1]);
      send(CT_A, KEY_A, 1'b1, PT_A, acc[2]);
      send(CT_B, KEY_B, 1'b1, PT_B, acc[3]);
      for (int i = 1; i < 4; i++) check("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'd18);
      wait_drain();

      // Reset in the middle of round 8 discards the block
      send(PT_A, KEY_A, 1'b0, CT_A, a);
      while (cyc < a + 7) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_out_data", bus.out_data, 64'd0);
      check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
      check("midrst_busy", 64'(busy), 64'd0);
      exp_q.delete();
      push_cnt--;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(PT_A, KEY_A, 1'b0, CT_A, a);
      wait_drain();
      repeat (5) @(negedge clk);
      check("pulse_count", 64'(hs_cnt), 64'(push_cnt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
